// File: rtl/instr_mem_loader.sv
// Streams a byte-wide program into the instruction RAM write port, packing bytes big-endian.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  fetch_hold,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  chk_err
);

  localparam int unsigned BPW   = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WW_W  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [WW_W-1:0]       ww_d, ww_inc;
  logic                  in_ready_d, we_d, hold_d, done_d;
  logic                  hs;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic                  chk_d;
`endif

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = ram_addr;
    data_d  = ram_data;
    ww_d    = words_written;
    hs      = in_valid & in_ready;
    ww_inc  = words_written + WW_W'(1);
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_err;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RECV;
          cnt_d   = '0;
          addr_d  = '0;
          ww_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          chk_d   = 1'b0;
`endif
        end
      end
      RECV: begin
        if (hs) begin
          // Shift left by one byte; the first byte ends up in the top byte lane.
          data_d = DATA_WIDTH'({ram_data, in_data});
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q ^ in_data;
`endif
          if (cnt_q == CNT_W'(BPW - 1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        ww_d = ww_inc;
        if (ww_inc == WW_W'(NUM_WORDS)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = ram_addr + ADDR_WIDTH'(1);
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs) begin
          chk_d   = (in_data != sum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == RECV)
`ifdef LOADER_CHECKSUM_EN
                 || (state_d == CHECK)
`endif
                 ;
    we_d   = (state_d == WRITE);
    done_d = (state_d == DONE);
    hold_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      in_ready      <= 1'b0;
      ram_addr      <= '0;
      ram_data      <= '0;
      ram_we        <= 1'b0;
      fetch_hold    <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready      <= in_ready_d;
      ram_addr      <= addr_d;
      ram_data      <= data_d;
      ram_we        <= we_d;
      fetch_hold    <= hold_d;
      done          <= done_d;
      words_written <= ww_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      chk_err <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      chk_err <= chk_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed loads plus randomized byte streams against a byte-queue model.
module tb_instr_mem_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 2;
  localparam int unsigned BPW = DW / 8;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic          fetch_hold;
  logic          done;
  logic [AW:0]   words_written;
  logic          chk_err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];

  instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .fetch_hold(fetch_hold), .done(done), .words_written(words_written), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Record every RAM write strike as seen mid-cycle.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte after `gap` idle cycles (garbage on in_data) and return at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_load(input bq_t bq, input int gap, input bit rnd_gap, input bit bad_chk,
                         input bit poke_start);
    logic [7:0]    x;
    logic [DW-1:0] w;
    int            t;
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_after_start", 64'(fetch_hold), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("ww_cleared", 64'(words_written), 64'd0);
    check("addr_cleared", 64'(ram_addr), 64'd0);
    x = 8'h00;
    for (int i = 0; i < bq.size(); i++) begin
      x ^= bq[i];
      if (poke_start && i == 5) start = 1'b1;
      send_byte(bq[i], rnd_gap ? int'($urandom_range(0, 3)) : gap);
      start = 1'b0;
      if ((i % BPW) == BPW - 1) check("we_latency", 64'(ram_we), 64'd1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, 0);
`else
    @(negedge clk);
    check("done_latency", 64'(done), 64'd1);
`endif
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("ww_final", 64'(words_written), 64'(NW));
    check("hold_released", 64'(fetch_hold), 64'd0);
    check("ready_in_done", 64'(in_ready), 64'd0);
    check("write_count", 64'(wr_addr_q.size()), 64'(NW));
    for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) w = (w << 8) | DW'(bq[k*BPW + b]);
      check("write_addr", 64'(wr_addr_q[k]), 64'(k));
      check("write_data", 64'(wr_data_q[k]), 64'(w));
    end
`ifdef LOADER_CHECKSUM_EN
    check("chk_err", 64'(chk_err), 64'(bad_chk));
`else
    check("chk_err_tied", 64'(chk_err), 64'd0);
`endif
  endtask

  initial begin
    bq_t bq;
    bq_t fixed;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    fixed    = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    #7;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_hold", 64'(fetch_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_ww", 64'(words_written), 64'd0);

    // Gap-free directed load, then the same stream with three idle cycles between bytes.
    do_load(fixed, 0, 1'b0, 1'b0, 1'b0);
    do_load(fixed, 3, 1'b0, 1'b0, 1'b0);
    // Start pulsed mid-load must be ignored; also restarts cleanly from DONE.
    do_load(fixed, 1, 1'b0, 1'b0, 1'b1);

    // Async reset part-way through a load.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 0);
    check("pre_rst_ww", 64'(words_written), 64'd1);
    check("pre_rst_addr", 64'(ram_addr), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_addr", 64'(ram_addr), 64'd0);
    check("mid_rst_data", 64'(ram_data), 64'd0);
    check("mid_rst_we", 64'(ram_we), 64'd0);
    check("mid_rst_hold", 64'(fetch_hold), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ww", 64'(words_written), 64'd0);
    check("mid_rst_chk", 64'(chk_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd0);
    do_load(fixed, 0, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    do_load(fixed, 0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized streams with random gaps.
    for (int r = 0; r < 8; r++) begin
      bq.delete();
      for (int i = 0; i < NW * BPW; i++) bq.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      do_load(bq, 0, 1'b1, 1'(r % 2), 1'b0);
`else
      do_load(bq, 0, 1'b1, 1'b0, 1'b0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
